// File: rtl/chord_mixer_fifo.sv
// Three-voice mixer with saturation and a small output FIFO that paces the chord player.
// Optional peak meter (peak_level port) is enabled by defining MIX_PEAK_HOLD_EN.
module chord_mixer_fifo #(
  parameter int DEPTH      = 8,
  parameter int ADDR_W     = 3,
  parameter int GAIN_SHIFT = 1,
  parameter int TIMEOUT    = 64
`ifdef MIX_PEAK_HOLD_EN
  , parameter int PEAK_DECAY = 4
`endif
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                play_enable,
  input  logic                sample_ready,
  input  logic signed [15:0]  sample1,
  input  logic signed [15:0]  sample2,
  input  logic signed [15:0]  sample3,
  input  logic                codec_ready,
  output logic                generate_next_sample,
  output logic signed [15:0]  sample_out,
  output logic                sample_valid,
  output logic [ADDR_W:0]     fifo_count,
  output logic                clip,
  output logic                underflow,
  output logic [1:0]          dbg_state_o
`ifdef MIX_PEAK_HOLD_EN
  , output logic [15:0]       peak_level
`endif
);

  // Handshakes: generate_next_sample is a one-cycle request; the player answers with
  // sample_ready (any later cycle while in WAIT). codec_ready pops one entry and is
  // answered one cycle later by a sample_valid pulse; no backpressure on either side.

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } state_e;

  localparam int TMO_W = $clog2(TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);
  localparam logic signed [17:0] MAX_S = 18'sd32767;
  localparam logic signed [17:0] MIN_S = -18'sd32768;

  state_e                state_q;
  logic                  gen_q;
  logic [TMO_W-1:0]      tmo_q;
  logic signed [15:0]    mix_q;
  logic                  mix_pend_q;
  logic                  clip_q;

  logic [15:0]           mem_q [DEPTH];
  logic [ADDR_W-1:0]     wr_ptr_q, rd_ptr_q;
  logic [ADDR_W:0]       count_q;
  logic signed [15:0]    sample_out_q;
  logic                  valid_q;
  logic                  underflow_q;

  logic signed [17:0]    sum_w, shifted_w;
  logic signed [15:0]    sat_w;
  logic                  sat_hit_w;
  logic [ADDR_W+1:0]     occ_w;
  logic                  push_w, pop_w, full_w, empty_w;

  always_comb begin
    sum_w     = $signed({{2{sample1[15]}}, sample1})
              + $signed({{2{sample2[15]}}, sample2})
              + $signed({{2{sample3[15]}}, sample3});
    shifted_w = sum_w >>> GAIN_SHIFT;
    sat_hit_w = 1'b0;
    sat_w     = shifted_w[15:0];
    if (shifted_w > MAX_S) begin
      sat_w     = 16'sh7fff;
      sat_hit_w = 1'b1;
    end else if (shifted_w < MIN_S) begin
      sat_w     = 16'sh8000;
      sat_hit_w = 1'b1;
    end
  end

  // A sample sitting in the mix register counts against free space, so a request is
  // never issued that could land in a full FIFO.
  assign occ_w   = {1'b0, count_q} + {{(ADDR_W+1){1'b0}}, mix_pend_q};
  assign push_w  = mix_pend_q;
  assign empty_w = (count_q == '0);
  assign full_w  = (count_q == (ADDR_W+1)'(DEPTH));
  assign pop_w   = codec_ready && !empty_w;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      gen_q      <= 1'b0;
      tmo_q      <= '0;
      mix_q      <= '0;
      mix_pend_q <= 1'b0;
      clip_q     <= 1'b0;
    end else begin
      gen_q      <= 1'b0;
      clip_q     <= 1'b0;
      mix_pend_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (play_enable && (occ_w < (ADDR_W+2)'(DEPTH))) begin
            state_q <= S_REQ;
            gen_q   <= 1'b1;
          end
        end
        S_REQ: begin
          tmo_q   <= '0;
          state_q <= play_enable ? S_WAIT : S_IDLE;
        end
        S_WAIT: begin
          if (!play_enable) begin
            state_q <= S_IDLE;
          end else if (sample_ready) begin
            mix_q      <= sat_w;
            clip_q     <= sat_hit_w;
            mix_pend_q <= 1'b1;
            state_q    <= S_IDLE;
          end else if (tmo_q == TMO_LAST) begin
            // Player went silent: substitute silence so the codec stream keeps flowing.
            mix_q      <= '0;
            mix_pend_q <= 1'b1;
            state_q    <= S_IDLE;
          end else begin
            tmo_q <= tmo_q + 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_w) mem_q[wr_ptr_q] <= mix_q;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      sample_out_q <= '0;
      valid_q      <= 1'b0;
      underflow_q  <= 1'b0;
    end else begin
      valid_q <= codec_ready;
      if (push_w) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (codec_ready) begin
        if (!empty_w) begin
          sample_out_q <= mem_q[rd_ptr_q];
          rd_ptr_q     <= rd_ptr_q + 1'b1;
        end else begin
          sample_out_q <= '0;
          underflow_q  <= 1'b1;
        end
      end
      case ({push_w, pop_w})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (!reset) !(push_w && full_w));

`ifdef MIX_PEAK_HOLD_EN
  logic [15:0] peak_q, abs_w, decay_w;

  always_comb begin
    if (!mix_q[15])              abs_w = mix_q;
    else if (mix_q == 16'sh8000) abs_w = 16'h7fff;
    else                         abs_w = -mix_q;
    decay_w = peak_q - (peak_q >> PEAK_DECAY);
  end

  always_ff @(posedge clk) begin
    if (!reset)      peak_q <= '0;
    else if (push_w) peak_q <= (abs_w > decay_w) ? abs_w : decay_w;
  end

  assign peak_level = peak_q;
`endif

  assign generate_next_sample = gen_q;
  assign sample_out           = sample_out_q;
  assign sample_valid         = valid_q;
  assign fifo_count           = count_q;
  assign clip                 = clip_q;
  assign underflow            = underflow_q;
  assign dbg_state_o          = state_q;

endmodule

// File: tb/tb_chord_mixer_fifo.sv
// Directed bench for chord_mixer_fifo: a small chord-player model answers requests,
// an expected queue tracks FIFO contents, and every check goes through check().
module tb_chord_mixer_fifo;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               reset, play_enable, sample_ready, codec_ready;
  logic signed [15:0] sample1, sample2, sample3;
  logic               generate_next_sample, sample_valid, clip, underflow;
  logic signed [15:0] sample_out;
  logic [3:0]         fifo_count;
  logic [1:0]         dbg_state;
`ifdef MIX_PEAK_HOLD_EN
  logic [15:0]        peak_level;
`endif

  chord_mixer_fifo dut (
    .clk                  (clk),
    .reset                (reset),
    .play_enable          (play_enable),
    .sample_ready         (sample_ready),
    .sample1              (sample1),
    .sample2              (sample2),
    .sample3              (sample3),
    .codec_ready          (codec_ready),
    .generate_next_sample (generate_next_sample),
    .sample_out           (sample_out),
    .sample_valid         (sample_valid),
    .fifo_count           (fifo_count),
    .clip                 (clip),
    .underflow            (underflow),
    .dbg_state_o          (dbg_state)
`ifdef MIX_PEAK_HOLD_EN
    , .peak_level         (peak_level)
`endif
  );

  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          req_cnt = 0;
  int          t0 = 0;
  bit          resp_q = 1'b0;
  bit          player_en = 1'b1;
  bit          clip_seen = 1'b0;
  logic [15:0] exp_q[$];

  logic signed [15:0] vec_v1  [5] = '{16'sd1000, 16'sd30000, -16'sd32768, -16'sd1000, 16'sd32767};
  logic signed [15:0] vec_v2  [5] = '{16'sd2000, 16'sd30000, -16'sd32768, 16'sd500,   16'sd32767};
  logic signed [15:0] vec_v3  [5] = '{16'sd3000, 16'sd30000, -16'sd32768, -16'sd3,    -16'sd32768};
  logic signed [15:0] vec_exp [5] = '{16'sd3000, 16'sd32767, -16'sd32768, -16'sd252,  16'sd16383};
  logic               vec_clip[5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One cycle: step to the falling edge, then play the chord player (answers one cycle
  // after seeing a request) and note request/clip pulses.
  task automatic tick();
    @(negedge clk);
    cyc++;
    if (generate_next_sample) req_cnt++;
    if (clip) clip_seen = 1'b1;
    sample_ready = resp_q;
    resp_q       = generate_next_sample && player_en;
  endtask

  task automatic wait_count(input int target, input int budget);
    for (int i = 0; i < budget && int'(fifo_count) != target; i++) tick();
  endtask

  task automatic pop_check(input string tag);
    logic [15:0] e;
    e = 16'h0;
    if (exp_q.size() != 0) e = exp_q.pop_front();
    codec_ready = 1'b1;
    tick();
    codec_ready = 1'b0;
    check({tag, "_valid"}, 32'(sample_valid), 32'd1);
    check({tag, "_data"}, {16'h0, sample_out}, {16'h0, e});
  endtask

  initial begin
    reset = 1'b0; play_enable = 1'b1; sample_ready = 1'b0; codec_ready = 1'b0;
    sample1 = '0; sample2 = '0; sample3 = '0;
    tick(); tick();
    check("rst_gen",   32'(generate_next_sample), 32'd0);
    check("rst_out",   {16'h0, sample_out}, 32'd0);
    check("rst_valid", 32'(sample_valid), 32'd0);
    check("rst_count", 32'(fifo_count), 32'd0);
    check("rst_clip",  32'(clip), 32'd0);
    check("rst_under", 32'(underflow), 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);

    play_enable = 1'b0; reset = 1'b1;
    tick(); tick();

    // One mix per vector: sum, shift, saturate, then read it back.
    for (int i = 0; i < 5; i++) begin
      sample1 = vec_v1[i]; sample2 = vec_v2[i]; sample3 = vec_v3[i];
      clip_seen = 1'b0;
      play_enable = 1'b1;
      wait_count(1, 20);
      play_enable = 1'b0;
      repeat (3) tick();
      exp_q.push_back(vec_exp[i]);
      check("vec_clip",  32'(clip_seen), 32'(vec_clip[i]));
      check("vec_count", 32'(fifo_count), 32'd1);
      pop_check("vec");
      check("vec_empty", 32'(fifo_count), 32'd0);
    end
    tick();
    check("hold_valid", 32'(sample_valid), 32'd0);
    check("hold_data",  {16'h0, sample_out}, 32'h3fff);

    // Fill with no reads: exactly DEPTH requests, then silence.
    sample1 = 16'sd100; sample2 = 16'sd200; sample3 = 16'sd300;
    req_cnt = 0;
    play_enable = 1'b1;
    repeat (80) tick();
    check("fill_reqs",  32'(req_cnt), 32'd8);
    check("fill_count", 32'(fifo_count), 32'd8);
    check("fill_gen",   32'(generate_next_sample), 32'd0);
    check("fill_state", 32'(dbg_state), 32'd0);
    play_enable = 1'b0;
    repeat (8) exp_q.push_back(16'd300);
    for (int i = 0; i < 4; i++) pop_check("drain");
    check("drain_count", 32'(fifo_count), 32'd4);

    // Push and pop on the same edge at occupancy 4.
    play_enable = 1'b1;
    for (int i = 0; i < 20 && !sample_ready; i++) tick();
    check("pp_ready",     32'(sample_ready), 32'd1);
    check("pp_pre_count", 32'(fifo_count), 32'd4);
    tick();
    play_enable = 1'b0;
    exp_q.push_back(16'd300);
    pop_check("pp");
    check("pp_count", 32'(fifo_count), 32'd4);
    repeat (3) tick();
    for (int i = 0; i < 4; i++) pop_check("drain2");
    check("drain2_count", 32'(fifo_count), 32'd0);
    check("pre_under",    32'(underflow), 32'd0);

    // Read from an empty FIFO: zero sample and sticky underflow.
    pop_check("under");
    check("under_flag", 32'(underflow), 32'd1);
    repeat (5) tick();
    check("under_sticky", 32'(underflow), 32'd1);
    check("under_valid",  32'(sample_valid), 32'd0);

    // Silent player: zero substituted after the timeout, then a fresh request.
    player_en = 1'b0;
    req_cnt = 0;
    play_enable = 1'b1;
    for (int i = 0; i < 10 && req_cnt == 0; i++) tick();
    t0 = cyc;
    wait_count(1, 100);
    check("tmo_latency", 32'(cyc - t0), 32'd66);
    check("tmo_count",   32'(fifo_count), 32'd1);
    check("tmo_rereq",   32'(req_cnt), 32'd2);
    repeat (2) tick();
    check("tmo_wait_state", 32'(dbg_state), 32'd2);

    // Reset while waiting clears everything on the next edge.
    reset = 1'b0;
    tick();
    check("rst2_count", 32'(fifo_count), 32'd0);
    check("rst2_under", 32'(underflow), 32'd0);
    check("rst2_state", 32'(dbg_state), 32'd0);
    check("rst2_gen",   32'(generate_next_sample), 32'd0);
    check("rst2_valid", 32'(sample_valid), 32'd0);
    reset = 1'b1;
    play_enable = 1'b0;
    exp_q.delete();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
